// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with branch/jump resolution, a 1024 x 32
// synchronous data memory and the MEM/WB pipeline register.
//
// Ports:
//   Clk, Reset                 clock (rising edge), async active-high reset
//   M_WB[3:0]                  writeback control {RegWrite, MemtoReg, Link, spare}
//   M_Branch/M_BNE/M_BranchCon branch qualifiers (beq, bne, ALU condition)
//   M_MemRead/M_MemWrite       load / store enables
//   M_jump/M_jr                direct jump / register jump
//   M_PCinc, M_BranchAddResult, M_ALUResult, M_WriteMemData, M_Read1  32-bit operands
//   M_ZeroFlag, M_offset[25:0], M_WriteRegData[4:0]
//   PCSrc, PCTarget, Flush     combinational redirect request / address / kill
//   WB_WB, WB_ReadData, WB_ALUResult, WB_PCinc, WB_WriteReg  MEM/WB register
//   MisalignErr                sticky misaligned-access flag
module mem_stage (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic [3:0]           M_WB,
   input  logic                 M_Branch,
   input  logic                 M_BNE,
   input  logic                 M_BranchCon,
   input  logic                 M_MemRead,
   input  logic                 M_MemWrite,
   input  logic                 M_jump,
   input  logic                 M_jr,
   input  logic [31:0]          M_PCinc,
   input  logic [31:0]          M_BranchAddResult,
   input  logic [31:0]          M_ALUResult,
   input  logic [31:0]          M_WriteMemData,
   input  logic [31:0]          M_Read1,
   input  logic                 M_ZeroFlag,
   input  logic [25:0]          M_offset,
   input  logic [4:0]           M_WriteRegData,
   output logic                 PCSrc,
   output logic [31:0]          PCTarget,
   output logic                 Flush,
   output logic [3:0]           WB_WB,
   output logic [31:0]          WB_ReadData,
   output logic [31:0]          WB_ALUResult,
   output logic [31:0]          WB_PCinc,
   output logic [4:0]           WB_WriteReg,
   output logic                 MisalignErr
);

   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 10;
   localparam int unsigned DEPTH = 1 << AW;

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] addr;
   logic          misalign;
   logic          taken;

   // Word index; bits above the 4 KB window are ignored so addresses wrap.
   assign addr     = M_ALUResult[AW+1:2];
   assign misalign = (M_ALUResult[1:0] != 2'b00);

   // Redirect resolution: jr > jump > taken branch.
   always_comb begin
      PCSrc    = 1'b0;
      PCTarget = M_PCinc;
      taken    = (M_Branch & M_ZeroFlag) | (M_BNE & ~M_ZeroFlag) |
                 (M_BranchCon & M_ALUResult[0]);
      if (M_jr) begin
         PCSrc    = 1'b1;
         PCTarget = M_Read1;
      end else if (M_jump) begin
         PCSrc    = 1'b1;
         PCTarget = {M_PCinc[31:28], M_offset, 2'b00};
      end else if (taken) begin
         PCSrc    = 1'b1;
         PCTarget = M_BranchAddResult;
      end
   end

   assign Flush = PCSrc;

   // MEM/WB register plus memory port. Memory is written only outside reset
   // and is never cleared by it; the read sees the pre-write word.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         WB_WB        <= '0;
         WB_ReadData  <= '0;
         WB_ALUResult <= '0;
         WB_PCinc     <= '0;
         WB_WriteReg  <= '0;
         MisalignErr  <= 1'b0;
      end else begin
         WB_WB        <= {M_WB[3] & (M_WriteRegData != 5'd0), M_WB[2:0]};
         WB_ALUResult <= M_ALUResult;
         WB_PCinc     <= M_PCinc;
         WB_WriteReg  <= M_WriteRegData;
         WB_ReadData  <= (M_MemRead && !misalign) ? mem[addr] : '0;
         if (M_MemWrite && !misalign)
            mem[addr] <= M_WriteMemData;
         if ((M_MemRead || M_MemWrite) && misalign)
            MisalignErr <= 1'b1;
      end
   end

endmodule
